// File: rtl/xform_seq.sv
// Sequencing controller for the 4x4 matrix-vector multiplier in the vertex path.
// Double-buffered matrix (host shadow bank, active bank) with a drain-before-swap policy.
module xform_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mat_we,
    input  logic [1:0]       mat_row,
    input  logic [39:0]      mat_data,
    input  logic             mat_commit,
    output logic             mat_busy,
    output logic             commit_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [39:0]      in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [39:0]      out_vec,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state_q;
    logic [39:0]       shadow_q [4];
    logic [39:0]       active_q [4];
    logic [3:0]        row_mask_q;
    logic [39:0]       out_vec_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  count_q;

    logic [9:0]        lane_d [4];
    logic [39:0]       result_d;
    logic              mask_full;
    logic              wr_ok;
    logic              in_hs;
    logic              out_hs;

    assign mask_full = (row_mask_q == 4'hF);
    assign wr_ok     = mat_we && (state_q != ST_DRAIN);
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;

    // Each lane is an unsigned dot product of one active row with the input, wrapped to 10 bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [39:0] row;
            assign row = active_q[gi];
            assign lane_d[gi] = row[39:30] * in_vec[39:30]
                              + row[29:20] * in_vec[29:20]
                              + row[19:10] * in_vec[19:10]
                              + row[9:0]   * in_vec[9:0];
        end
    endgenerate

    assign result_d = {lane_d[0], lane_d[1], lane_d[2], lane_d[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            row_mask_q  <= 4'h0;
            out_vec_q   <= 40'h0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 40'h0;
                active_q[i] <= 40'h0;
            end
        end else begin
            err_q <= 1'b0;

            if (wr_ok) begin
                shadow_q[mat_row]   <= mat_data;
                row_mask_q[mat_row] <= 1'b1;
            end

            // Commit decisions look at the mask as it stood before this cycle's write.
            case (state_q)
                ST_EMPTY: begin
                    if (mat_commit) begin
                        if (mask_full) begin
                            for (int i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
                            row_mask_q <= wr_ok ? (4'b0001 << mat_row) : 4'h0;
                            state_q    <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (mat_commit) begin
                        if (mask_full) begin
                            state_q <= ST_DRAIN;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q) begin
                        for (int i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
                        row_mask_q <= 4'h0;
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    busy_q  <= 1'b0;
                end
            endcase

            if (in_hs) begin
                out_vec_q   <= result_d;
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end

            if (out_hs) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign mat_busy   = busy_q;
    assign commit_err = err_q;
    assign out_valid  = out_valid_q;
    assign out_vec    = out_vec_q;
    assign vec_count  = count_q;

endmodule

// File: doc/xform_seq.md
# xform_seq

Sequencing controller for the 4x4 matrix–vector multiplier (`mmulp`) in the vertex path. It holds a double-buffered 4-row matrix: a shadow bank written by the host and an active bank driving `mmulp`. It streams 40-bit vectors through the multiplier with valid/ready handshakes on both sides. A matrix swap drains in-flight results first, so every output vector is computed entirely with one matrix.

## Interface
Parameters:
- `CNT_W`, 16: width of the output-vector counter.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mat_we`  in  1: write `mat_data` into shadow row `mat_row`.
- `mat_row`  in  2: shadow row index 0..3. Row 0 is the `A0` (top-lane) row.
- `mat_data`  in  40: packed row {e0,e1,e2,e3}, 10 bits each, MSB first.
- `mat_commit`  in  1: request promotion of the shadow bank to the active bank.
- `mat_busy`  out  1: high while in DRAIN. `mat_we` and `mat_commit` are ignored while it is high.
- `commit_err`  out  1: one-cycle pulse when a commit is rejected because the shadow bank is incomplete.
- `in_valid`  in  1: input vector valid.
- `in_ready`  out  1: input vector accepted when `in_valid && in_ready`.
- `in_vec`  in  40: packed {x,y,z,w}, 10 bits each.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result when `out_valid && out_ready`.
- `out_vec`  out  40: packed result {c0,c1,c2,c3}.
- `vec_count`  out  CNT_W: number of completed output handshakes.

## Operation
Storage and datapath:
- Shadow bank: four 40-bit registers plus a 4-bit `row_mask`. Each accepted write sets `row_mask[mat_row]`. Rewriting a row overwrites it.
- Active bank: four 40-bit registers wired to `mmulp` A0..A3. `in_vec` drives `P`.
- Output register: `out_vec` / `out_valid`, loaded from `mmulp.C` on an input handshake.
- Arithmetic is `mmulp`'s: each lane is an unsigned dot product truncated modulo 2^10. No saturation, no overflow flag.

States:
- EMPTY (reset): no valid active matrix; `in_ready`=0.
  - `mat_commit` with `row_mask`==4'hF: copy shadow to active, clear `row_mask`, go to RUN.
- RUN: `in_ready` = !`out_valid` || `out_ready`.
  - `mat_commit` with full mask: go to DRAIN.
- DRAIN: `in_ready`=0 and `mat_busy`=1.
  - In the first cycle where `out_valid`==0 (after reset, or after the last result has left): copy shadow to active, clear `row_mask`, go to RUN.

Commit and write rules:
- A commit with `row_mask`!=4'hF, in EMPTY or RUN, is ignored, pulses `commit_err`, and leaves the state unchanged.
- A commit in DRAIN is ignored without an error pulse.
- `mat_commit` evaluates `row_mask` as it was before any same-cycle `mat_we`. The same-cycle write still lands in shadow.
- For an EMPTY commit, that same-cycle write is not part of the copy. It stays in shadow and `row_mask` keeps only that row's bit.

Output register and counter:
- Output register update:
  - On an input handshake: load the result, `out_valid`=1.
  - Otherwise, on an output handshake: `out_valid`=0.
  - `out_vec` holds its value when `out_valid`=0.
- `vec_count` increments on each output handshake and wraps modulo 2^CNT_W.

Reset:
- Any cycle with `rst`=1 returns every register to its reset value, mid-stream or mid-drain. An in-flight result is discarded.
- Reset values:
  - `out_valid`=0, `out_vec`=0, `in_ready`=0, `mat_busy`=0, `commit_err`=0, `vec_count`=0.
  - `row_mask`=0; both banks all-zero; state EMPTY.

## Timing
- Latency: input handshake in cycle N gives `out_valid`=1 in cycle N+1.
- Throughput: 1 vector per cycle while `out_ready` is held high.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. All other outputs are registered.
- Backpressure: with `out_ready`=0 and `out_valid`=1, `in_ready`=0 and `out_vec` is held stable.
- Commit in RUN at cycle N:
  - If the output register is empty at N+1, the new matrix is active at N+2 and `in_ready` can rise at N+2.
  - Otherwise the swap waits for the output to drain.
- Commit in EMPTY at cycle N: RUN at N+1, with the new matrix active.
- `commit_err` is high in cycle N+1 for a rejected commit at cycle N.

## Test plan
- Identity:
  - Stimulus: write rows 40'h0040000000, 40'h0000100000, 40'h0000000400, 40'h0000000001; commit; send 40'h0040200C04.
  - Required: `out_vec`=40'h0040200C04 one cycle after acceptance; `vec_count`=1.
- Overflow:
  - Stimulus: all rows 40'hFFFFFFFFFF; input {1,1,1,1}=40'h0040100401.
  - Required: every lane is 10'h3FC; `out_vec`=40'hFF3FCFF3FC.
- Incomplete commit:
  - Stimulus: write rows 0–2 only; commit.
  - Required: `commit_err` pulses once; state stays EMPTY; `in_ready` stays 0.
- Swap under backpressure:
  - Stimulus: stream in RUN with the identity matrix; hold `out_ready`=0; load 2x-scale rows 40'h0080000000, 40'h0000200000, 40'h0000000800, 40'h0000000002; commit.
  - Required: `mat_busy`=1 and `in_ready`=0 until the pending identity result is taken. The next vector 40'h0040200C04 then yields 40'h0080401808.
- Streaming:
  - Stimulus: 100 vectors with random `in_valid`/`out_ready` stalls.
  - Required: results in order, each matching the reference model; `vec_count`=100; no duplicated or lost vectors.
- Reset mid-stream:
  - Stimulus: assert `rst` for 1 cycle with `out_valid`=1.
  - Required: next cycle all outputs are at reset values; state EMPTY; a new commit is needed before any vector is accepted.
